// File: rtl/dig_divider_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : dig_divider_sequencer_if
// Brief    : Control and status bundle for the divider run-control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface dig_divider_sequencer_if #(
    parameter int BITS       = 16,
    parameter int COUNT_BITS = 8
);
    logic [BITS-1:0]       PORT_div;
    logic                  PORT_ld;
    logic [COUNT_BITS-1:0] PORT_n;
    logic                  PORT_start;
    logic                  PORT_stop;
    logic                  PORT_en;
    logic                  PORT_out;
    logic                  PORT_busy;
    logic                  PORT_done;
    logic [COUNT_BITS-1:0] PORT_cnt;

    modport master (
        output PORT_div, PORT_ld, PORT_n, PORT_start, PORT_stop,
        input  PORT_en, PORT_out, PORT_busy, PORT_done, PORT_cnt
    );

    modport slave (
        input  PORT_div, PORT_ld, PORT_n, PORT_start, PORT_stop,
        output PORT_en, PORT_out, PORT_busy, PORT_done, PORT_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dig_divider_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dig_divider_sequencer
// Brief    : Start/stop sequencer for a clock divider with a shadowed divisor,
//            tick enable, square-wave output and fixed-length burst mode.
// Revision : 1.0 - initial release
// ============================================================================
module dig_divider_sequencer #(
    parameter int BITS       = 16,
    parameter int COUNT_BITS = 8
) (
    input  wire logic                PORT_C,
    input  wire logic                PORT_clr,
    dig_divider_sequencer_if.slave   bus
);
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                state_q,     state_d;
    logic [BITS-1:0]       counter_q,   counter_d;
    logic [BITS-1:0]       active_q,    active_d;
    logic [BITS-1:0]       pending_q,   pending_d;
    logic                  pend_flag_q, pend_flag_d;
    logic [COUNT_BITS-1:0] burst_q,     burst_d;
    logic [COUNT_BITS-1:0] cnt_q,       cnt_d;
    logic                  en_q,        en_d;
    logic                  out_q,       out_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic [COUNT_BITS-1:0] cnt_inc_w;
    assign cnt_inc_w = cnt_q + COUNT_BITS'(1);

    always_ff @(posedge PORT_C or posedge PORT_clr) begin
        if (PORT_clr) begin
            state_q     <= S_IDLE;
            counter_q   <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_flag_q <= 1'b0;
            burst_q     <= '0;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            out_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_flag_q <= pend_flag_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_flag_d = pend_flag_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        en_d        = 1'b0;
        out_d       = out_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.PORT_ld) begin
                    active_d = bus.PORT_div;
                end
                if (bus.PORT_start && !bus.PORT_stop) begin
                    state_d   = S_RUN;
                    counter_d = '0;
                    cnt_d     = '0;
                    burst_d   = bus.PORT_n;
                end
            end

            S_RUN: begin
                if (bus.PORT_stop) begin
                    // Abort wins over a coincident tick; any shadowed divisor is dropped.
                    state_d     = S_IDLE;
                    counter_d   = '0;
                    pend_flag_d = 1'b0;
                end else if (counter_q == active_q) begin
                    counter_d = '0;
                    en_d      = 1'b1;
                    out_d     = ~out_q;
                    cnt_d     = cnt_inc_w;
                    // Divisor changes only take effect on a period boundary.
                    if (bus.PORT_ld) begin
                        active_d    = bus.PORT_div;
                        pend_flag_d = 1'b0;
                    end else if (pend_flag_q) begin
                        active_d    = pending_q;
                        pend_flag_d = 1'b0;
                    end
                    if ((burst_q != '0) && (cnt_inc_w == burst_q)) begin
                        done_d      = 1'b1;
                        state_d     = S_IDLE;
                        pend_flag_d = 1'b0;
                    end
                end else begin
                    counter_d = counter_q + BITS'(1);
                    if (bus.PORT_ld) begin
                        pending_d   = bus.PORT_div;
                        pend_flag_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
    end

    assign bus.PORT_en   = en_q;
    assign bus.PORT_out  = out_q;
    assign bus.PORT_busy = busy_q;
    assign bus.PORT_done = done_q;
    assign bus.PORT_cnt  = cnt_q;
endmodule
`default_nettype wire
